// File: rtl/fpmul_pkg.sv
// Shared definitions for the FP multiplier issue slice.
//   state_t  : issue FSM states
//   cls_t    : per-operand classification flags
//   EXP_MAX  : all-ones single-precision exponent
//   QNAN     : canonical quiet NaN returned on watchdog timeout
//   TIMEOUT_DEF : default Done watchdog limit in cycles
package fpmul_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
        logic dnf;   // denormal input, flushed to zero
    } cls_t;

    localparam logic [7:0]  EXP_MAX     = 8'hFF;
    localparam logic [31:0] QNAN        = 32'h7FC0_0000;
    localparam int          TIMEOUT_DEF = 15;

endpackage

// File: rtl/fpmul_issue_if.sv
// Multiplier control-unit bus.
//   master (issue side): drives Start pulse, held operands A/B and
//                        pre-classified NaN/Inf/Zero; receives Done/P.
//   slave  (multiplier): the reverse.
interface fpmul_issue_if #(
    parameter int W = 32
);
    logic         Start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         NaN;
    logic         Inf;
    logic         Zero;
    logic         Done;
    logic [W-1:0] P;

    modport master (output Start, A, B, NaN, Inf, Zero, input Done, P);
    modport slave  (input Start, A, B, NaN, Inf, Zero, output Done, P);
endinterface

// File: rtl/fpmul_classify.sv
// Combinational IEEE-754 single operand classifier.
//   mag : operand without its sign bit (exponent + mantissa)
//   cls : nan / inf / zero (denormals count as zero) / dnf (was denormal)
module fpmul_classify
    import fpmul_pkg::*;
(
    input  logic [30:0] mag,
    output cls_t        cls
);
    logic [7:0]  exp;
    logic [22:0] man;

    assign exp = mag[30:23];
    assign man = mag[22:0];

    always_comb begin
        cls      = '0;
        cls.nan  = (exp == EXP_MAX) && (man != '0);
        cls.inf  = (exp == EXP_MAX) && (man == '0);
        cls.zero = (exp == 8'h00);
        cls.dnf  = (exp == 8'h00) && (man != '0);
    end
endmodule

// File: rtl/fpmul_issue.sv
// Issue/retire wrapper around a multi-cycle FP multiplier control unit.
// Accepts one operand pair, pulses Start with operands and special-case
// flags held stable, waits for Done under a watchdog, then holds the
// result until the consumer takes it. Strictly one operation in flight.
//   clk, rst              : clock, async active-low reset
//   in_valid/in_ready/in_a/in_b : operand handshake
//   mul                   : multiplier bus (master side)
//   out_valid/out_ready/out_p/out_* : result handshake and flags
module fpmul_issue
    import fpmul_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int W       = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    fpmul_issue_if.master mul,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_p,
    output logic         out_nan,
    output logic         out_inf,
    output logic         out_zero,
    output logic         out_dnf,
    output logic         out_to
);
    localparam int             CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TMAX = CW'(TIMEOUT);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          live;        // low until the first clock after reset release
    logic          accept, cap_done, cap_to;
    logic [W-1:0]  a_q, b_q;
    logic          nan_q, inf_q, zero_q, dnf_q;
    cls_t          cls_a, cls_b;
    logic          nan_c, inf_c, zero_c;

    fpmul_classify u_cls_a (.mag(in_a[30:0]), .cls(cls_a));
    fpmul_classify u_cls_b (.mag(in_b[30:0]), .cls(cls_b));

    // inf*zero is invalid; otherwise NaN dominates Inf dominates Zero.
    assign nan_c  = cls_a.nan | cls_b.nan | (cls_a.inf & cls_b.zero) | (cls_a.zero & cls_b.inf);
    assign inf_c  = ~nan_c & (cls_a.inf | cls_b.inf);
    assign zero_c = ~nan_c & ~inf_c & (cls_a.zero | cls_b.zero);

    assign in_ready  = (state == IDLE) & live;
    assign out_valid = (state == HOLD);
    assign mul.Start = (state == ISSUE);
    assign mul.A     = a_q;
    assign mul.B     = b_q;
    assign mul.NaN   = nan_q;
    assign mul.Inf   = inf_q;
    assign mul.Zero  = zero_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Done is only looked at in WAIT, so stray pulses elsewhere fall away.
    // Done in the last watchdog cycle wins over the timeout.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        cap_done  = 1'b0;
        cap_to    = 1'b0;
        unique case (state)
            IDLE:  if (in_valid && in_ready) begin
                       accept    = 1'b1;
                       state_nxt = ISSUE;
                   end
            ISSUE: state_nxt = WAIT;
            WAIT:  if (mul.Done) begin
                       cap_done  = 1'b1;
                       state_nxt = HOLD;
                   end else if (cnt == TMAX) begin
                       cap_to    = 1'b1;
                       state_nxt = HOLD;
                   end
            HOLD:  if (out_ready) state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live     <= 1'b0;
            cnt      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            nan_q    <= 1'b0;
            inf_q    <= 1'b0;
            zero_q   <= 1'b0;
            dnf_q    <= 1'b0;
            out_p    <= '0;
            out_nan  <= 1'b0;
            out_inf  <= 1'b0;
            out_zero <= 1'b0;
            out_dnf  <= 1'b0;
            out_to   <= 1'b0;
        end else begin
            live <= 1'b1;
            if (accept) begin
                a_q    <= in_a;
                b_q    <= in_b;
                nan_q  <= nan_c;
                inf_q  <= inf_c;
                zero_q <= zero_c;
                dnf_q  <= cls_a.dnf | cls_b.dnf;
            end
            if (state == ISSUE)
                cnt <= '0;
            else if (state == WAIT && cnt != TMAX)
                cnt <= cnt + CW'(1);
            if (cap_done) begin
                out_p    <= mul.P;
                out_nan  <= nan_q;
                out_inf  <= inf_q;
                out_zero <= zero_q;
                out_dnf  <= dnf_q;
                out_to   <= 1'b0;
            end else if (cap_to) begin
                // Timeout reports a quiet NaN; the denormal note still
                // describes the operands, so it is kept.
                out_p    <= W'(QNAN);
                out_nan  <= 1'b1;
                out_inf  <= 1'b0;
                out_zero <= 1'b0;
                out_dnf  <= dnf_q;
                out_to   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fpmul_issue.sv
module tb_fpmul_issue;
    localparam int TO = 15;
    localparam logic [31:0] QNAN_V = 32'h7FC0_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0, in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_p;
    logic        out_nan, out_inf, out_zero, out_dnf, out_to;

    int n_vec = 0;
    int n_err = 0;

    fpmul_issue_if #(.W(32)) mif ();

    fpmul_issue #(.TIMEOUT(TO), .W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mul(mif),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
        .out_nan(out_nan), .out_inf(out_inf), .out_zero(out_zero),
        .out_dnf(out_dnf), .out_to(out_to)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Operand kinds: 0 normal, 1 zero (incl. denormal), 2 inf, 3 nan
    function automatic int kind(input logic [31:0] x);
        int e = int'(x[30:23]);
        if (e == 255) return (x[22:0] != 0) ? 3 : 2;
        if (e == 0)   return 1;
        return 0;
    endfunction

    // {NaN, Inf, Zero, dnf} of a product of a and b
    function automatic logic [3:0] model_flags(input logic [31:0] a, input logic [31:0] b);
        int ka = kind(a), kb = kind(b);
        logic n, i, z, d;
        n = (ka == 3) || (kb == 3) || (ka == 2 && kb == 1) || (ka == 1 && kb == 2);
        i = !n && (ka == 2 || kb == 2);
        z = !n && !i && (ka == 1 || kb == 1);
        d = (a[30:23] == 0 && a[22:0] != 0) || (b[30:23] == 0 && b[22:0] != 0);
        return {n, i, z, d};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] r = $urandom;
        case ($urandom_range(0, 5))
            0: return {r[31], 8'hFF, 23'h0};
            1: return {r[31], 8'hFF, r[22:1], 1'b1};
            2: return {r[31], 8'h00, 23'h0};
            3: return {r[31], 8'h00, r[22:1], 1'b1};
            default: return {r[31], 8'($urandom_range(1, 254)), r[22:0]};
        endcase
    endfunction

    // One full operation. dly = cycle (counted from the Start cycle = 0) in
    // which Done is pulsed; the block listens for TO+1 cycles after Start.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int dly,
                          input int stall, input logic [31:0] p);
        logic [3:0]  fl = model_flags(a, b);
        bit          eff = (dly >= 1) && (dly <= TO + 1);
        int          exp_t = eff ? dly + 1 : TO + 2;
        logic [31:0] exp_p = eff ? p : QNAN_V;
        logic [4:0]  exp_o = eff ? {fl, 1'b0} : {3'b100, fl[0], 1'b1};
        int t = 0, n = 0, starts = 0;

        in_valid = 1'b1; in_a = a; in_b = b;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        chk("accept", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
        chk("start", mif.Start, 1);
        chk("opA", mif.A, a);
        chk("opB", mif.B, b);
        chk("pre_flags", {mif.NaN, mif.Inf, mif.Zero}, fl[3:1]);
        mif.Done = (t == dly); mif.P = (t == dly) ? p : $urandom;
        while (1) begin
            @(negedge clk); t++;
            if (mif.Start) starts++;
            if (out_valid || t > TO + 6) break;
            mif.Done = (t == dly); mif.P = (t == dly) ? p : $urandom;
        end
        chk("out_valid", out_valid, 1);
        chk("latency", t, exp_t);
        chk("out_p", out_p, exp_p);
        chk("out_flags", {out_nan, out_inf, out_zero, out_dnf, out_to}, exp_o);
        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            in_valid = 1'b1; in_a = rand_op(); in_b = rand_op();
            mif.Done = (t == dly); mif.P = $urandom;
            @(negedge clk); t++;
            if (mif.Start) starts++;
            chk("stall_ready", in_ready, 0);
            chk("stall_valid", out_valid, 1);
            chk("stall_p", out_p, exp_p);
            chk("stall_A", mif.A, a);
        end
        in_valid = 1'b0;
        mif.Done = (t == dly); mif.P = $urandom;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; mif.Done = 1'b0;
        chk("release_valid", out_valid, 0);
        chk("release_ready", in_ready, 1);
        chk("start_count", starts, 0);
    endtask

    initial begin
        mif.Done = 1'b0; mif.P = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", in_ready, 0);
        chk("rst_start", mif.Start, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_AB", {mif.A, mif.B} == 64'h0, 1);
        chk("rst_p", out_p, 0);
        chk("rst_flags", {mif.NaN, mif.Inf, mif.Zero, out_nan, out_inf, out_zero, out_dnf, out_to}, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", in_ready, 1);

        run_op(32'h3F80_0000, 32'h4000_0000, 8, 0, 32'h4000_0000);
        run_op(32'h7F80_0000, 32'h0000_0000, 3, 1, 32'h1234_5678);
        run_op(32'h0000_0001, 32'h3F80_0000, 4, 0, 32'h0000_0000);
        run_op(32'h4040_0000, 32'h4080_0000, 99, 0, 32'h4140_0000);
        run_op(32'h4040_0000, 32'h4080_0000, 0, 2, 32'h4140_0000);
        run_op(32'h4040_0000, 32'h4080_0000, TO + 1, 0, 32'h4140_0000);
        run_op(32'h3F80_0000, 32'h3F80_0000, 2, 5, 32'h3F80_0000);
        for (int k = 0; k < 40; k++)
            run_op(rand_op(), rand_op(), int'($urandom_range(0, TO + 4)),
                   int'($urandom_range(0, 4)), $urandom);

        // Reset in the middle of WAIT, then a late Done must be ignored.
        in_valid = 1'b1; in_a = 32'h3F80_0000; in_b = 32'h4000_0000;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_A", mif.A, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        mif.Done = 1'b1; mif.P = 32'hDEAD_BEEF;
        @(negedge clk);
        mif.Done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("late_done_valid", out_valid, 0);
            chk("late_done_idle", in_ready, 1);
            chk("late_done_start", mif.Start, 0);
            @(negedge clk);
        end
        run_op(32'h3F80_0000, 32'h4000_0000, 5, 1, 32'h4000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
